// File: rtl/voter_pkg.sv
// Shared defaults and helper functions for the TMR sequential voter.
// The popcount works on a fixed-width vector; callers zero-extend their channel masks.
package voter_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_N_CH       = 3;
    localparam int DEF_ERR_THRESH = 4;
    localparam int MAX_CH         = 64;

    // Bits needed to hold a saturating count from 0 up to thresh.
    function automatic int cnt_width(input int thresh);
        return $clog2(thresh + 1);
    endfunction

    function automatic logic [7:0] popcount(input logic [MAX_CH-1:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/voter_ch_monitor.sv
// Per-channel health monitor: saturating mismatch counter plus a sticky fail flag
// that rises on the same edge the counter reaches the threshold.
module voter_ch_monitor
    import voter_pkg::*;
#(
    parameter int ERR_THRESH = DEF_ERR_THRESH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clear_i,
    output logic fail_o
);

    localparam int CNT_W = cnt_width(ERR_THRESH);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(ERR_THRESH);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             fail_q, fail_d;

    assign cnt_inc = cnt_q + 1'b1;

    // Clear wins over a same-cycle increment.
    always_comb begin
        cnt_d  = cnt_q;
        fail_d = fail_q;
        if (clear_i) begin
            cnt_d  = '0;
            fail_d = 1'b0;
        end else if (inc_i && (cnt_q != THRESH)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == THRESH) begin
                fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fail_q <= fail_d;
        end
    end

    assign fail_o = fail_q;

endmodule

// File: rtl/tmr_voter_seq.sv
// N-way redundant bitwise majority voter with registered output, tie hold and
// automatic exclusion of channels that keep disagreeing with the vote.
module tmr_voter_seq
    import voter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int N_CH       = DEF_N_CH,
    parameter int ERR_THRESH = DEF_ERR_THRESH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [N_CH*WIDTH-1:0] data_i,
    input  logic                  clear_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      vote_o,
    output logic [N_CH-1:0]       mismatch_o,
    output logic [N_CH-1:0]       fail_o,
    output logic                  tie_o,
    output logic                  fail_all_o
);

    if (N_CH < 3 || (N_CH % 2) == 0 || N_CH > MAX_CH) begin : g_bad_n_ch
        $error("tmr_voter_seq: N_CH must be odd, >= 3 and <= MAX_CH");
    end
    if (ERR_THRESH < 1 || ERR_THRESH > 255) begin : g_bad_thresh
        $error("tmr_voter_seq: ERR_THRESH must be in 1..255");
    end

    // Wide enough to hold 2*N_CH so the majority compare never overflows.
    localparam int CW = $clog2(N_CH + 1) + 1;

    logic [N_CH-1:0]   fail_w;
    logic [N_CH-1:0]   active;
    logic [N_CH-1:0]   inc;
    logic [MAX_CH-1:0] act_ext;
    logic [MAX_CH-1:0] col_ext;
    logic [CW-1:0]     a_cnt;
    logic [CW-1:0]     ones;
    logic [CW-1:0]     ones_x2;

    logic [WIDTH-1:0]  vote_q, vote_d;
    logic [N_CH-1:0]   mismatch_q, mismatch_d;
    logic              tie_q, tie_d;
    logic              valid_q;

    always_comb begin
        active              = ~fail_w;
        act_ext             = '0;
        act_ext[N_CH-1:0]   = active;
        a_cnt               = CW'(popcount(act_ext));
        vote_d              = vote_q;
        tie_d               = 1'b0;
        mismatch_d          = '0;
        col_ext             = '0;
        ones                = '0;
        ones_x2             = '0;
        // With no active channel every bit would look tied; that case holds silently.
        if (a_cnt != '0) begin
            for (int b = 0; b < WIDTH; b++) begin
                col_ext = '0;
                for (int k = 0; k < N_CH; k++) begin
                    col_ext[k] = active[k] & data_i[k*WIDTH + b];
                end
                ones    = CW'(popcount(col_ext));
                ones_x2 = {ones[CW-2:0], 1'b0};
                if (ones_x2 > a_cnt) begin
                    vote_d[b] = 1'b1;
                end else if (ones_x2 < a_cnt) begin
                    vote_d[b] = 1'b0;
                end else begin
                    tie_d = 1'b1;
                end
            end
            for (int k = 0; k < N_CH; k++) begin
                mismatch_d[k] = active[k] && (data_i[k*WIDTH +: WIDTH] != vote_d);
            end
        end
    end

    assign inc = valid_i ? mismatch_d : '0;

    for (genvar k = 0; k < N_CH; k++) begin : g_mon
        voter_ch_monitor #(
            .ERR_THRESH (ERR_THRESH)
        ) u_mon (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .inc_i   (inc[k]),
            .clear_i (clear_i),
            .fail_o  (fail_w[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= 1'b0;
            vote_q     <= '0;
            mismatch_q <= '0;
            tie_q      <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                vote_q     <= vote_d;
                mismatch_q <= mismatch_d;
                tie_q      <= tie_d;
            end
        end
    end

    assign valid_o    = valid_q;
    assign vote_o     = vote_q;
    assign mismatch_o = mismatch_q;
    assign tie_o      = tie_q;
    assign fail_o     = fail_w;
    assign fail_all_o = &fail_w;

endmodule

// File: tb/tb_tmr_voter_seq.sv
// Directed bench for tmr_voter_seq (3 channels, 8 bits, threshold 4).
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_tmr_voter_seq;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [23:0] data_i;
    logic        clear_i;
    logic        valid_o;
    logic [7:0]  vote_o;
    logic [2:0]  mismatch_o;
    logic [2:0]  fail_o;
    logic        tie_o;
    logic        fail_all_o;

    int total = 0;
    int bad   = 0;

    tmr_voter_seq #(
        .WIDTH      (8),
        .N_CH       (3),
        .ERR_THRESH (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .clear_i    (clear_i),
        .valid_o    (valid_o),
        .vote_o     (vote_o),
        .mismatch_o (mismatch_o),
        .fail_o     (fail_o),
        .tie_o      (tie_o),
        .fail_all_o (fail_all_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pack(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    // Present one cycle of inputs, then settle just after the capturing edge.
    task automatic step(input logic [23:0] d, input logic v, input logic c);
        @(negedge clk);
        data_i  = d;
        valid_i = v;
        clear_i = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid_i = 1'b1;
        clear_i = 1'b0;
        data_i  = pack(8'h11, 8'h22, 8'h33);
        repeat (2) @(posedge clk);
        #1;
        total++; if (vote_o !== 8'h00) begin bad++; $display("FAIL reset_vote got=%h want=00", vote_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (mismatch_o !== 3'b000) begin bad++; $display("FAIL reset_mismatch got=%b want=000", mismatch_o); end
        total++; if (tie_o !== 1'b0) begin bad++; $display("FAIL reset_tie got=%b want=0", tie_o); end
        total++; if (fail_o !== 3'b000) begin bad++; $display("FAIL reset_fail got=%b want=000", fail_o); end
        total++; if (fail_all_o !== 1'b0) begin bad++; $display("FAIL reset_fail_all got=%b want=0", fail_all_o); end
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_idle_valid cyc=%0d got=%b want=0", i, valid_o); end
        end
    endtask

    task automatic test_vote();
        step(pack(8'hA5, 8'hA5, 8'h5A), 1'b1, 1'b0);
        total++; if (vote_o !== 8'hA5) begin bad++; $display("FAIL vote_value got=%h want=a5", vote_o); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL vote_valid got=%b want=1", valid_o); end
        total++; if (mismatch_o !== 3'b100) begin bad++; $display("FAIL vote_mismatch got=%b want=100", mismatch_o); end
        total++; if (tie_o !== 1'b0) begin bad++; $display("FAIL vote_tie got=%b want=0", tie_o); end
        step(pack(8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", valid_o); end
        total++; if (vote_o !== 8'hA5) begin bad++; $display("FAIL idle_vote_hold got=%h want=a5", vote_o); end
        total++; if (mismatch_o !== 3'b100) begin bad++; $display("FAIL idle_mismatch_hold got=%b want=100", mismatch_o); end
    endtask

    task automatic test_exclusion();
        step(24'h0, 1'b0, 1'b1);
        total++; if (fail_o !== 3'b000) begin bad++; $display("FAIL excl_clear got=%b want=000", fail_o); end
        for (int i = 0; i < 4; i++) begin
            step(pack(8'hA5, 8'hA5, 8'hA5 ^ 8'(i + 1)), 1'b1, 1'b0);
            total++; if (vote_o !== 8'hA5) begin bad++; $display("FAIL excl_vote i=%0d got=%h want=a5", i, vote_o); end
            total++; if (mismatch_o !== 3'b100) begin bad++; $display("FAIL excl_mismatch i=%0d got=%b want=100", i, mismatch_o); end
            total++; if (fail_o !== ((i == 3) ? 3'b100 : 3'b000)) begin bad++; $display("FAIL excl_fail i=%0d got=%b want=%b", i, fail_o, (i == 3) ? 3'b100 : 3'b000); end
        end
        step(pack(8'hFF, 8'h00, 8'h33), 1'b1, 1'b0);
        total++; if (vote_o !== 8'hA5) begin bad++; $display("FAIL tie_vote_hold got=%h want=a5", vote_o); end
        total++; if (tie_o !== 1'b1) begin bad++; $display("FAIL tie_flag got=%b want=1", tie_o); end
        total++; if (mismatch_o !== 3'b011) begin bad++; $display("FAIL tie_mismatch got=%b want=011", mismatch_o); end
        total++; if (fail_o !== 3'b100) begin bad++; $display("FAIL tie_fail got=%b want=100", fail_o); end
    endtask

    task automatic test_clear_priority();
        // ch0 carries one earlier mismatch; only a real clear lets it survive three more.
        step(pack(8'h00, 8'h00, 8'hFF), 1'b1, 1'b1);
        total++; if (vote_o !== 8'h00) begin bad++; $display("FAIL clr_vote got=%h want=00", vote_o); end
        total++; if (mismatch_o !== 3'b000) begin bad++; $display("FAIL clr_mismatch got=%b want=000", mismatch_o); end
        total++; if (tie_o !== 1'b0) begin bad++; $display("FAIL clr_tie got=%b want=0", tie_o); end
        step(24'h0, 1'b0, 1'b0);
        total++; if (fail_o !== 3'b000) begin bad++; $display("FAIL clr_fail got=%b want=000", fail_o); end
        for (int i = 0; i < 4; i++) begin
            step(pack(8'h0F, 8'h3C, 8'h3C), 1'b1, 1'b0);
            total++; if (vote_o !== 8'h3C) begin bad++; $display("FAIL clr_cnt_vote i=%0d got=%h want=3c", i, vote_o); end
            total++; if (mismatch_o !== 3'b001) begin bad++; $display("FAIL clr_cnt_mismatch i=%0d got=%b want=001", i, mismatch_o); end
            total++; if (fail_o !== ((i == 3) ? 3'b001 : 3'b000)) begin bad++; $display("FAIL clr_cnt_fail i=%0d got=%b want=%b", i, fail_o, (i == 3) ? 3'b001 : 3'b000); end
        end
        step(24'h0, 1'b0, 1'b1);
        total++; if (fail_o !== 3'b000) begin bad++; $display("FAIL clr_again got=%b want=000", fail_o); end
    endtask

    task automatic test_total_fail();
        for (int i = 0; i < 4; i++) begin
            step(pack(8'h3C, 8'h3C, 8'hC3), 1'b1, 1'b0);
            total++; if (fail_o !== ((i == 3) ? 3'b100 : 3'b000)) begin bad++; $display("FAIL tf_ch2 i=%0d got=%b want=%b", i, fail_o, (i == 3) ? 3'b100 : 3'b000); end
        end
        for (int i = 0; i < 4; i++) begin
            step(pack(8'hFF, 8'h00, 8'h55), 1'b1, 1'b0);
            total++; if (vote_o !== 8'h3C) begin bad++; $display("FAIL tf_vote i=%0d got=%h want=3c", i, vote_o); end
            total++; if (tie_o !== 1'b1) begin bad++; $display("FAIL tf_tie i=%0d got=%b want=1", i, tie_o); end
            total++; if (mismatch_o !== 3'b011) begin bad++; $display("FAIL tf_mismatch i=%0d got=%b want=011", i, mismatch_o); end
            total++; if (fail_all_o !== (i == 3)) begin bad++; $display("FAIL tf_fail_all i=%0d got=%b want=%b", i, fail_all_o, i == 3); end
        end
        total++; if (fail_o !== 3'b111) begin bad++; $display("FAIL tf_fail got=%b want=111", fail_o); end
        step(pack(8'h12, 8'h34, 8'h56), 1'b1, 1'b0);
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL none_valid got=%b want=1", valid_o); end
        total++; if (vote_o !== 8'h3C) begin bad++; $display("FAIL none_vote got=%h want=3c", vote_o); end
        total++; if (mismatch_o !== 3'b000) begin bad++; $display("FAIL none_mismatch got=%b want=000", mismatch_o); end
        total++; if (tie_o !== 1'b0) begin bad++; $display("FAIL none_tie got=%b want=0", tie_o); end
        total++; if (fail_all_o !== 1'b1) begin bad++; $display("FAIL none_fail_all got=%b want=1", fail_all_o); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = pack(8'hAA, 8'hAA, 8'hAA);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (vote_o !== 8'h00) begin bad++; $display("FAIL mid_rst_vote got=%h want=00", vote_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", valid_o); end
        total++; if (fail_o !== 3'b000) begin bad++; $display("FAIL mid_rst_fail got=%b want=000", fail_o); end
        total++; if (fail_all_o !== 1'b0) begin bad++; $display("FAIL mid_rst_fail_all got=%b want=0", fail_all_o); end
        total++; if (mismatch_o !== 3'b000 || tie_o !== 1'b0) begin bad++; $display("FAIL mid_rst_flags got=%b/%b want=000/0", mismatch_o, tie_o); end
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            total++; if (valid_o !== 1'b0 || vote_o !== 8'h00) begin bad++; $display("FAIL mid_rst_idle cyc=%0d got=%b/%h want=0/00", i, valid_o, vote_o); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ch [3];
        logic [7:0] m_vote;
        logic [2:0] m_fail;
        int         m_cnt [3];
        logic [7:0] ev;
        logic [2:0] em;
        logic       et;
        logic [7:0] base;
        int         a;
        int         ones;
        m_vote = 8'h00;
        m_fail = 3'b000;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        for (int i = 0; i < 16; i++) begin
            base  = 8'(i * 8'h11) ^ 8'h5A;
            ch[0] = ((i % 7) == 3) ? (base ^ 8'h0F) : base;
            ch[1] = ((i % 4) == 1) ? (base ^ 8'h81) : base;
            ch[2] = ((i % 5) == 2) ? ~base : base;
            a = 0;
            for (int k = 0; k < 3; k++) if (!m_fail[k]) a++;
            ev = m_vote;
            em = 3'b000;
            et = 1'b0;
            if (a > 0) begin
                for (int b = 0; b < 8; b++) begin
                    ones = 0;
                    for (int k = 0; k < 3; k++) if (!m_fail[k] && ch[k][b]) ones++;
                    if (2 * ones > a) ev[b] = 1'b1;
                    else if (2 * ones < a) ev[b] = 1'b0;
                    else et = 1'b1;
                end
                for (int k = 0; k < 3; k++) em[k] = !m_fail[k] && (ch[k] != ev);
            end
            m_vote = ev;
            for (int k = 0; k < 3; k++) begin
                if (em[k] && m_cnt[k] < 4) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == 4) m_fail[k] = 1'b1;
                end
            end
            step(pack(ch[0], ch[1], ch[2]), 1'b1, 1'b0);
            total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid i=%0d got=%b want=1", i, valid_o); end
            total++; if (vote_o !== ev) begin bad++; $display("FAIL b2b_vote i=%0d got=%h want=%h", i, vote_o, ev); end
            total++; if (mismatch_o !== em || tie_o !== et) begin bad++; $display("FAIL b2b_flags i=%0d got=%b/%b want=%b/%b", i, mismatch_o, tie_o, em, et); end
            total++; if (fail_o !== m_fail) begin bad++; $display("FAIL b2b_fail i=%0d got=%b want=%b", i, fail_o, m_fail); end
        end
        step(24'h0, 1'b0, 1'b0);
        total++; if (valid_o !== 1'b0 || vote_o !== m_vote) begin bad++; $display("FAIL b2b_tail got=%b/%h want=0/%h", valid_o, vote_o, m_vote); end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        clear_i = 1'b0;
        data_i  = '0;
        test_reset();
        test_vote();
        test_exclusion();
        test_clear_priority();
        test_total_fail();
        test_reset_midstream();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
